// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: two write-back requesters, load issue tracking,
// decode hazard query and the register-file write port.
interface wb_arbiter_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic                      ALU_VALID;
   logic [ADDR_WIDTH-1:0]     ALU_RD;
   logic [DATA_WIDTH-1:0]     ALU_DATA;
   logic                      ALU_READY;
   logic                      MEM_VALID;
   logic [ADDR_WIDTH-1:0]     MEM_RD;
   logic [DATA_WIDTH-1:0]     MEM_DATA;
   logic                      MEM_READY;
   logic                      ISSUE_VALID;
   logic [ADDR_WIDTH-1:0]     ISSUE_RD;
   logic [ADDR_WIDTH-1:0]     RS1_SEL;
   logic [ADDR_WIDTH-1:0]     RS2_SEL;
   logic                      HAZARD;
   logic                      WEN;
   logic [ADDR_WIDTH-1:0]     RD_SEL;
   logic [DATA_WIDTH-1:0]     WB_DATA;
   logic [2**ADDR_WIDTH-1:0]  PENDING;

   modport slave (
      input  ALU_VALID, ALU_RD, ALU_DATA, MEM_VALID, MEM_RD, MEM_DATA,
             ISSUE_VALID, ISSUE_RD, RS1_SEL, RS2_SEL,
      output ALU_READY, MEM_READY, HAZARD, WEN, RD_SEL, WB_DATA, PENDING
   );

   modport master (
      output ALU_VALID, ALU_RD, ALU_DATA, MEM_VALID, MEM_RD, MEM_DATA,
             ISSUE_VALID, ISSUE_RD, RS1_SEL, RS2_SEL,
      input  ALU_READY, MEM_READY, HAZARD, WEN, RD_SEL, WB_DATA, PENDING
   );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: picks ALU or load result for the single register-file
// write port, tracks outstanding loads and flags decode-stage hazards.
//
// state     | meaning
// GRANT_ALU | last transfer went to the ALU; MEM wins the next contention
// GRANT_MEM | last transfer went to MEM (also reset); ALU wins next contention
module wb_arbiter #(
   parameter int ADDR_WIDTH   = 5,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_PRIORITY = 0
) (
   input logic          CLK,
   input logic          RESET,
   wb_arbiter_if.slave  bus
);
   localparam int NREG = 2**ADDR_WIDTH;

   typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} grant_t;

   grant_t                 last_grant, last_grant_nxt;
   logic                   alu_ready, mem_ready;
   logic                   wen_q;
   logic [ADDR_WIDTH-1:0]  rd_sel_q;
   logic [DATA_WIDTH-1:0]  wb_data_q;
   logic [NREG-1:0]        pending_q, pending_nxt;
   logic                   hz1, hz2;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) last_grant <= GRANT_MEM;
      else        last_grant <= last_grant_nxt;
   end

   // READY already implies VALID, so READY doubles as the transfer strobe.
   always_comb begin
      alu_ready      = 1'b0;
      mem_ready      = 1'b0;
      last_grant_nxt = last_grant;
      if (RESET) begin
         if (bus.ALU_VALID && bus.MEM_VALID) begin
            if (MEM_PRIORITY != 0 || last_grant == GRANT_ALU) mem_ready = 1'b1;
            else                                               alu_ready = 1'b1;
         end else begin
            alu_ready = bus.ALU_VALID;
            mem_ready = bus.MEM_VALID;
         end
      end
      if (alu_ready)      last_grant_nxt = GRANT_ALU;
      else if (mem_ready) last_grant_nxt = GRANT_MEM;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wen_q     <= 1'b0;
         rd_sel_q  <= '0;
         wb_data_q <= '0;
      end else if (alu_ready) begin
         wen_q     <= |bus.ALU_RD;
         rd_sel_q  <= bus.ALU_RD;
         wb_data_q <= bus.ALU_DATA;
      end else if (mem_ready) begin
         wen_q     <= |bus.MEM_RD;
         rd_sel_q  <= bus.MEM_RD;
         wb_data_q <= bus.MEM_DATA;
      end else begin
         wen_q     <= 1'b0;
      end
   end

   // Issue is applied after the load clear so a same-edge set wins.
   always_comb begin
      pending_nxt = pending_q;
      if (mem_ready) pending_nxt[bus.MEM_RD] = 1'b0;
      if (bus.ISSUE_VALID && (bus.ISSUE_RD != '0)) pending_nxt[bus.ISSUE_RD] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) pending_q <= '0;
      else        pending_q <= pending_nxt;
   end

   assign hz1 = (bus.RS1_SEL != '0) &&
                (pending_q[bus.RS1_SEL] || (wen_q && rd_sel_q == bus.RS1_SEL));
   assign hz2 = (bus.RS2_SEL != '0) &&
                (pending_q[bus.RS2_SEL] || (wen_q && rd_sel_q == bus.RS2_SEL));

   assign bus.ALU_READY = alu_ready;
   assign bus.MEM_READY = mem_ready;
   assign bus.HAZARD    = hz1 || hz2;
   assign bus.WEN       = wen_q;
   assign bus.RD_SEL    = rd_sel_q;
   assign bus.WB_DATA   = wb_data_q;
   assign bus.PENDING   = pending_q;
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_WIDTH, 5, register index width (fixed)
  DATA_WIDTH, 32, write-back data width (fixed)
  MEM_PRIORITY, 0, 0 = round-robin between ALU and MEM; 1 = MEM always wins contention
REQ-002 Ports SHALL be, one per line:
  CLK  in  1  single clock, all state on rising edge
  RESET  in  1  asynchronous, active-low reset
  ALU_VALID  in  1  ALU write-back request
  ALU_RD  in  5  ALU destination index
  ALU_DATA  in  32  ALU result
  ALU_READY  out  1  ALU request accepted this cycle
  MEM_VALID  in  1  load write-back request
  MEM_RD  in  5  load destination index
  MEM_DATA  in  32  load data
  MEM_READY  out  1  load request accepted this cycle
  ISSUE_VALID  in  1  load issued this cycle
  ISSUE_RD  in  5  destination index of issued load
  RS1_SEL  in  5  decode-stage source 1 index
  RS2_SEL  in  5  decode-stage source 2 index
  HAZARD  out  1  decode must stall
  WEN  out  1  register file write enable
  RD_SEL  out  5  register file write index
  WB_DATA  out  32  register file write data
  PENDING  out  32  outstanding-load bitmap, bit n = register n
REQ-003 The design SHALL use one clock (CLK) and an asynchronous active-low reset (RESET), exactly as named above.

Function
REQ-004 Transfer SHALL occur on a requester when VALID and READY are both high at a rising edge; at most one transfer per cycle.
REQ-005 READY SHALL be combinational: only one VALID high -> that requester's READY = 1; none high -> both READY = 0.
REQ-006 Both VALID high, MEM_PRIORITY = 0: grant SHALL go to the requester not recorded in LAST_GRANT; LAST_GRANT updates on every transfer, including RD = 0 transfers.
REQ-007 Both VALID high, MEM_PRIORITY = 1: MEM_READY = 1 and ALU_READY = 0.
REQ-008 Loser SHALL hold VALID/RD/DATA stable until accepted; the block does not buffer unaccepted requests.
REQ-009 Output stage SHALL be registered, 1-cycle latency: transfer at edge N -> WEN/RD_SEL/WB_DATA show it during cycle N+1.
REQ-010 WEN SHALL be 1 for exactly one cycle per transfer with RD != 0; RD = 0 transfers are accepted but give WEN = 0.
REQ-011 Cycles with no transfer SHALL give WEN = 0 while RD_SEL/WB_DATA hold their last values.
REQ-012 ISSUE_VALID with ISSUE_RD != 0 SHALL set PENDING[ISSUE_RD] at the next edge; ISSUE_RD = 0 is ignored; PENDING[0] is always 0.
REQ-013 A MEM transfer SHALL clear PENDING[MEM_RD] at the same edge.
REQ-014 Set and clear of the same bit at one edge: set SHALL win. Setting an already-set bit leaves it set; upstream guarantees one outstanding load per register.
REQ-015 ALU transfers SHALL NOT modify PENDING.
REQ-016 HAZARD SHALL be combinational and equal to the OR over RS1_SEL and RS2_SEL of:
  - index != 0, and
  - PENDING[index] = 1, or (WEN = 1 and RD_SEL = index).

Reset
REQ-017 RESET low SHALL immediately clear WEN, RD_SEL, WB_DATA and PENDING to 0 and set LAST_GRANT = MEM, independent of CLK.
REQ-018 While RESET is low, ALU_READY and MEM_READY SHALL be 0; HAZARD follows REQ-016 on the cleared state.
REQ-019 Reset mid-operation SHALL drop any in-flight write and all pending bits; the first edge after release behaves as after power-up.

Verification
REQ-020 Release reset, ALU_VALID = 1, ALU_RD = 3, ALU_DATA = 0xDEADBEEF -> ALU_READY = 1; next cycle WEN = 1, RD_SEL = 3, WB_DATA = 0xDEADBEEF; following cycle WEN = 0.
REQ-021 MEM_PRIORITY = 0, both VALID held 4 cycles (ALU_RD = 1, MEM_RD = 2) -> grant order ALU, MEM, ALU, MEM; WEN pulses with RD_SEL 1, 2, 1, 2. MEM_PRIORITY = 1, same stimulus -> MEM granted every cycle.
REQ-022 ISSUE_VALID with ISSUE_RD = 5, then RS1_SEL = 5 -> PENDING = 0x20 and HAZARD = 1. MEM transfer with MEM_RD = 5 -> PENDING = 0; HAZARD stays 1 during the WEN cycle, then drops to 0.
REQ-023 Same edge: ISSUE_RD = 7 and MEM transfer with MEM_RD = 7 -> PENDING[7] = 1. ISSUE_RD = 0 -> PENDING unchanged. ALU_RD = 0 transfer -> WEN stays 0 and next contention is granted to MEM.
REQ-024 PENDING = 0x0000_0F00 and a transfer in flight, then RESET pulsed low mid-cycle -> WEN, PENDING and HAZARD = 0 immediately without a clock edge; first contention after release is granted to ALU.
